input_scheduler: RTL and testbench
==================================

Name: input_scheduler

Overview:
- Shares the game core's single move-command port between the player buttons and the gravity timer.
- Edge-detects button presses and queues them in a small FIFO.
- Generates gravity DOWN commands at a period that shrinks with level, where level is derived from score.
- Presents one command at a time to the game core over a valid/ready handshake, replacing the core's raw button and 1 Hz/5 Hz pulse inputs.

Parameters:
- FifoDepth, 4: button-command queue depth (power of two, 2..16).
- GravityBase, 50: gravity period at level 0, in ticks.
- GravityStep, 4: period reduction per level, in ticks.
- GravityMin, 5: floor on the gravity period, in ticks.
- DownPeriod, 5: gravity period while down is held, in ticks.
- LinesPerLevel, 10: score increment per level.
- MaxLevel, 9: level saturation value.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle base time pulse (nominal 100 Hz).
- down  in  1  level, synchronized; held = fast drop.
- left  in  1  level, synchronized.
- right  in  1  level, synchronized.
- leftRotate  in  1  level, synchronized.
- rightRotate  in  1  level, synchronized.
- score  in  14  current line count from the game core.
- gameover  in  1  game core is in the game-over state.
- cmd_ready  in  1  game core accepts a command this cycle.
- cmd_valid  out  1  a command is presented.
- cmd_op  out  3  command: 1=DOWN, 2=LEFT, 3=RIGHT, 4=LROT, 5=RROT; 0 when not valid.
- level  out  4  current level, 0..MaxLevel.
- overflow  out  1  sticky flag: a button press was dropped because the FIFO was full.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high. On reset, every register clears: cmd_valid=0, cmd_op=0, level=0, overflow=0, FIFO empty, gravity counter=0, gravity pending=0, button history=0.
- Edge detect: a press is a button sampled 1 while its previous sample was 0. Holding a button produces exactly one press.
- Simultaneous presses: if several presses occur in one cycle, only the highest-priority one is queued and the rest are discarded. Priority order is LROT > RROT > LEFT > RIGHT. The down button is never queued; it only changes the gravity period.
- FIFO full: a press arriving while the FIFO is full is dropped and overflow is set. overflow clears only on reset.
- FIFO read and write together: allowed in the same cycle, and a press is accepted if the FIFO is full but being read that cycle.
- Gravity period: down ? DownPeriod : max(GravityMin, GravityBase − level×GravityStep). Compute this in 8-bit unsigned arithmetic and clamp before the subtraction can underflow.
- Gravity counter: increments on each tick. When the tick makes counter+1 ≥ period, the counter goes to 0 and gravity pending is set. Because the compare is ≥, a period that shortens mid-count fires on the next tick. Pending is a single sticky bit: extra fires while it is already set are lost, not counted.
- Output stage: a register (cmd_valid, cmd_op). It loads when it is empty, or when a transfer (cmd_valid & cmd_ready) happens this cycle, so back-to-back transfers run at one per cycle.
- Load source priority: gravity pending first, else FIFO head, else empty. Loading DOWN clears pending; loading from the FIFO pops the head.
- Handshake hold: while cmd_valid=1 and cmd_ready=0, cmd_valid and cmd_op hold stable.
- Latency: a press sampled at edge n is written into the FIFO at edge n. With the output stage empty and no gravity pending, cmd_valid rises at edge n+1.
- Level, increase: a threshold register starts at LinesPerLevel. When score ≥ threshold and level < MaxLevel, level increments and threshold increases by LinesPerLevel. This is at most one step per cycle, so a large score jump converges over several cycles.
- Level, restart: if score < threshold − LinesPerLevel (new game cleared the score), level goes to 0 and threshold goes to LinesPerLevel in one cycle.
- Gameover high, per cycle: flush the FIFO, clear pending, clear the gravity counter, force cmd_valid=0 and cmd_op=0 (even mid-handshake), and ignore presses. level and overflow hold.
- Gameover falling: scheduling resumes on the next cycle from the flushed state.

Test Plan:
1. Press left for 1 cycle with cmd_ready=1 → cmd_valid high for exactly 1 cycle with cmd_op=2, starting one cycle after the press.
2. Hold cmd_ready=0 and press LEFT, RIGHT, LROT, RROT, then LEFT again → the first four are queued; the fifth press: if the output stage has already taken one entry (queue 3 + stage 1), it is queued; a subsequent press is dropped and sets overflow=1. Release cmd_ready → ops 2,3,4,5 then the queued LEFT, in order, with no gaps.
3. Assert leftRotate and right on the same cycle → a single op=4; right is never issued.
4. score=0, no buttons, cmd_ready=1 → DOWN every 50 ticks. Set score=25 → level=2 within 2 cycles, DOWN every 42 ticks. Set score=200 → level saturates at 9, period = max(5, 50−36) = 14. Hold down → period 5.
5. Gravity fires while a LEFT is queued and the output stage is empty → DOWN is issued first, then LEFT. Two fires while cmd_ready=0 → only one DOWN is issued.
6. Raise gameover mid-handshake with 3 ops queued → cmd_valid=0 the next cycle, the FIFO is empty after gameover falls, and no stale op is ever issued. Drop score to 0 → level=0 the next cycle.

Source files
------------

// File: rtl/input_scheduler.sv
// Arbitrates button presses (edge-detected, queued) and level-dependent gravity
// ticks onto a single valid/ready move-command port for the game core.
module input_scheduler #(
  parameter int FifoDepth     = 4,
  parameter int GravityBase   = 50,
  parameter int GravityStep   = 4,
  parameter int GravityMin    = 5,
  parameter int DownPeriod    = 5,
  parameter int LinesPerLevel = 10,
  parameter int MaxLevel      = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        leftRotate,
  input  logic        rightRotate,
  input  logic [13:0] score,
  input  logic        gameover,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [2:0]  cmd_op,
  output logic [3:0]  level,
  output logic        overflow
);

  localparam int AW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FifoDepth);
  localparam logic [14:0] LPL_C = 15'(LinesPerLevel);
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_DOWN  = 3'd1;
  localparam logic [2:0] OP_LEFT  = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_LROT  = 3'd4;
  localparam logic [2:0] OP_RROT  = 3'd5;

  logic [3:0]    btn_prev_reg;
  logic [3:0]    btn_now;
  logic [3:0]    press;
  logic [2:0]    press_op;
  logic [2:0]    fifo_mem [FifoDepth];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   count_reg;
  logic          fifo_empty;
  logic          fifo_full;
  logic          load;
  logic          pop;
  logic          push;
  logic          drop;
  logic [7:0]    cnt_reg;
  logic [8:0]    cnt_inc;
  logic [7:0]    reduction;
  logic [7:0]    period;
  logic          fire;
  logic          pend_reg;
  logic          valid_reg;
  logic [2:0]    op_reg;
  logic [3:0]    level_reg;
  logic [14:0]   thresh_reg;
  logic [14:0]   score_ext;
  logic          restart;
  logic          level_up;
  logic          overflow_reg;

  // Order: left, right, leftRotate, rightRotate
  assign btn_now = {left, right, leftRotate, rightRotate};
  assign press   = btn_now & ~btn_prev_reg;

  always_comb begin
    press_op = OP_NONE;
    if (press[1])      press_op = OP_LROT;
    else if (press[0]) press_op = OP_RROT;
    else if (press[3]) press_op = OP_LEFT;
    else if (press[2]) press_op = OP_RIGHT;
  end

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == DEPTH_C);
  assign load       = ~valid_reg | cmd_ready;
  assign pop        = load & ~pend_reg & ~fifo_empty;
  assign push       = (press_op != OP_NONE) & (~fifo_full | pop);
  assign drop       = (press_op != OP_NONE) & fifo_full & ~pop;

  // Clamp before subtracting so a high level can never wrap the period.
  always_comb begin
    reduction = 8'(level_reg) * 8'(GravityStep);
    if (down)
      period = 8'(DownPeriod);
    else if (reduction >= 8'(GravityBase) - 8'(GravityMin))
      period = 8'(GravityMin);
    else
      period = 8'(GravityBase) - reduction;
  end

  assign cnt_inc = {1'b0, cnt_reg} + 9'd1;
  assign fire    = tick & (cnt_inc >= {1'b0, period});

  assign score_ext = {1'b0, score};
  assign restart   = score_ext < (thresh_reg - LPL_C);
  assign level_up  = (score_ext >= thresh_reg) && (level_reg < 4'(MaxLevel));

  always_ff @(posedge clk) begin
    if (!reset && !gameover && push)
      fifo_mem[wr_ptr_reg] <= press_op;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev_reg <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      cnt_reg      <= '0;
      pend_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      op_reg       <= OP_NONE;
      level_reg    <= '0;
      thresh_reg   <= LPL_C;
      overflow_reg <= 1'b0;
    end else begin
      btn_prev_reg <= btn_now;
      if (gameover) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
        cnt_reg    <= '0;
        pend_reg   <= 1'b0;
        valid_reg  <= 1'b0;
        op_reg     <= OP_NONE;
      end else begin
        if (load) begin
          if (pend_reg) begin
            valid_reg <= 1'b1;
            op_reg    <= OP_DOWN;
          end else if (!fifo_empty) begin
            valid_reg <= 1'b1;
            op_reg    <= fifo_mem[rd_ptr_reg];
          end else begin
            valid_reg <= 1'b0;
            op_reg    <= OP_NONE;
          end
        end
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
        if (drop) overflow_reg <= 1'b1;
        if (tick) cnt_reg <= fire ? 8'd0 : cnt_inc[7:0];
        // A fire coinciding with a DOWN load re-arms pending for the next slot.
        pend_reg <= fire | (pend_reg & ~load);
        if (restart) begin
          level_reg  <= '0;
          thresh_reg <= LPL_C;
        end else if (level_up) begin
          level_reg  <= level_reg + 4'd1;
          thresh_reg <= thresh_reg + LPL_C;
        end
      end
    end
  end

  assign cmd_valid = valid_reg;
  assign cmd_op    = op_reg;
  assign level     = level_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_input_scheduler.sv
// Directed and randomized checks of input_scheduler against a queue-based
// cycle model built from the command-arbitration rules.
module tb_input_scheduler;

  localparam int DEPTH = 4;
  localparam int GBASE = 50;
  localparam int GSTEP = 4;
  localparam int GMIN  = 5;
  localparam int DPER  = 5;
  localparam int LPL   = 10;
  localparam int MAXL  = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        down = 1'b0;
  logic        left = 1'b0;
  logic        right = 1'b0;
  logic        lrot = 1'b0;
  logic        rrot = 1'b0;
  logic [13:0] score = '0;
  logic        gameover = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [3:0]  level;
  logic        overflow;

  int total = 0;
  int bad = 0;

  // reference model state
  int  m_q[$];
  bit  m_pend;
  int  m_cnt;
  int  m_lvl;
  int  m_thr;
  bit  m_v;
  int  m_op;
  bit  m_ovf;
  bit  p_l, p_r, p_lr, p_rr;

  input_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .down(down), .left(left),
    .right(right), .leftRotate(lrot), .rightRotate(rrot), .score(score),
    .gameover(gameover), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (observed=running expected=done)");
    $fatal(1, "watchdog");
  end

  function automatic int grav_period(bit dn, int lvl);
    int p;
    if (dn) return DPER;
    p = GBASE - lvl * GSTEP;
    return (p > GMIN) ? p : GMIN;
  endfunction

  task automatic model_cycle();
    int pop_op;
    bit load;
    int per;
    if (reset) begin
      m_q.delete(); m_pend = 0; m_cnt = 0; m_lvl = 0; m_thr = LPL;
      m_v = 0; m_op = 0; m_ovf = 0; p_l = 0; p_r = 0; p_lr = 0; p_rr = 0;
      return;
    end
    pop_op = 0;
    if (lrot && !p_lr)       pop_op = 4;
    else if (rrot && !p_rr)  pop_op = 5;
    else if (left && !p_l)   pop_op = 2;
    else if (right && !p_r)  pop_op = 3;
    p_l = left; p_r = right; p_lr = lrot; p_rr = rrot;
    if (gameover) begin
      m_q.delete(); m_pend = 0; m_cnt = 0; m_v = 0; m_op = 0;
      return;
    end
    per  = grav_period(down, m_lvl);
    load = !m_v || cmd_ready;
    if (load) begin
      if (m_pend) begin
        m_v = 1; m_op = 1; m_pend = 0;
      end else if (m_q.size() > 0) begin
        m_v = 1; m_op = m_q.pop_front();
      end else begin
        m_v = 0; m_op = 0;
      end
    end
    if (pop_op != 0) begin
      if (m_q.size() < DEPTH) m_q.push_back(pop_op);
      else m_ovf = 1;
    end
    if (tick) begin
      if (m_cnt + 1 >= per) begin m_cnt = 0; m_pend = 1; end
      else m_cnt = m_cnt + 1;
    end
    if (int'(score) < m_thr - LPL) begin
      m_lvl = 0; m_thr = LPL;
    end else if (int'(score) >= m_thr && m_lvl < MAXL) begin
      m_lvl = m_lvl + 1; m_thr = m_thr + LPL;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      if (!reset && !gameover && cmd_valid && cmd_ready)
        $display("t=%0t xfer op=%0d level=%0d", $time, cmd_op, level);
      model_cycle();
      @(posedge clk);
      #1;
      chk("cmd_valid", 16'(cmd_valid), 16'(m_v));
      chk("cmd_op", 16'(cmd_op), 16'(m_op));
      chk("level", 16'(level), 16'(m_lvl));
      chk("overflow", 16'(overflow), 16'(m_ovf));
    end
  endtask

  task automatic wait_down(output int cycles);
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while (!(cmd_valid && cmd_op == 3'd1) && cycles < 300);
    if (cycles >= 300) chk("down_timeout", 16'(0), 16'(1));
  endtask

  task automatic press1(input int which);
    case (which)
      2: left = 1'b1;
      3: right = 1'b1;
      4: lrot = 1'b1;
      default: rrot = 1'b1;
    endcase
    cyc();
    left = 1'b0; right = 1'b0; lrot = 1'b0; rrot = 1'b0;
    cyc();
  endtask

  initial begin
    int c;
    int seq[6];
    int exp_ops[5];
    exp_ops = '{2, 3, 4, 5, 2};
    seq = '{2, 3, 4, 5, 2, 3};

    // reset
    reset = 1'b1;
    cyc(2);
    chk("rst_valid", 16'(cmd_valid), 16'(0));
    chk("rst_op", 16'(cmd_op), 16'(0));
    chk("rst_level", 16'(level), 16'(0));
    chk("rst_ovf", 16'(overflow), 16'(0));
    reset = 1'b0;

    // single LEFT press, one-cycle command one cycle later
    cmd_ready = 1'b1;
    left = 1'b1;
    cyc();
    chk("t1_not_yet", 16'(cmd_valid), 16'(0));
    left = 1'b0;
    cyc();
    chk("t1_valid", 16'(cmd_valid), 16'(1));
    chk("t1_op", 16'(cmd_op), 16'(2));
    cyc();
    chk("t1_gone", 16'(cmd_valid), 16'(0));

    // stalled consumer: fill queue, then overflow
    cmd_ready = 1'b0;
    for (int i = 0; i < 6; i++) press1(seq[i]);
    chk("t2_ovf", 16'(overflow), 16'(1));
    chk("t2_hold_op", 16'(cmd_op), 16'(2));
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_order_valid", 16'(cmd_valid), 16'(1));
      chk("t2_order_op", 16'(cmd_op), 16'(exp_ops[i]));
      cyc();
    end
    chk("t2_drained", 16'(cmd_valid), 16'(0));

    // simultaneous presses: LROT wins
    lrot = 1'b1; right = 1'b1;
    cyc();
    lrot = 1'b0; right = 1'b0;
    cyc();
    chk("t3_op", 16'(cmd_op), 16'(4));
    cyc();
    chk("t3_only_one", 16'(cmd_valid), 16'(0));

    // gravity periods by level and fast drop
    reset = 1'b1; cyc(); reset = 1'b0;
    tick = 1'b1; cmd_ready = 1'b1; score = 14'd0;
    wait_down(c);
    wait_down(c);
    chk("t4_period50", 16'(c), 16'(50));
    score = 14'd25;
    cyc(2);
    chk("t4_level2", 16'(level), 16'(2));
    wait_down(c);
    wait_down(c);
    chk("t4_period42", 16'(c), 16'(42));
    score = 14'd200;
    cyc(8);
    chk("t4_level9", 16'(level), 16'(9));
    wait_down(c);
    wait_down(c);
    chk("t4_period14", 16'(c), 16'(14));
    down = 1'b1;
    wait_down(c);
    wait_down(c);
    chk("t4_period5", 16'(c), 16'(5));
    down = 1'b0;

    // gravity beats a queued press; sticky pending while stalled
    score = 14'd0; tick = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
    tick = 1'b1;
    cyc(49);
    left = 1'b1;
    cyc();
    left = 1'b0;
    cyc();
    chk("t5_down_first", 16'(cmd_op), 16'(1));
    cyc();
    chk("t5_left_second", 16'(cmd_op), 16'(2));
    cmd_ready = 1'b0;
    cyc(110);
    cmd_ready = 1'b1;
    cyc(6);

    // gameover mid-handshake flushes everything
    tick = 1'b0; score = 14'd25;
    cyc(3);
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) press1(seq[i]);
    gameover = 1'b1;
    cyc();
    chk("t6_valid_killed", 16'(cmd_valid), 16'(0));
    cyc(2);
    chk("t6_level_hold", 16'(level), 16'(2));
    gameover = 1'b0;
    cmd_ready = 1'b1;
    cyc(5);
    chk("t6_no_stale", 16'(cmd_valid), 16'(0));
    score = 14'd0;
    cyc();
    chk("t6_level_restart", 16'(level), 16'(0));

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      left      = ($urandom_range(0, 3) == 0);
      right     = ($urandom_range(0, 3) == 0);
      lrot      = ($urandom_range(0, 4) == 0);
      rrot      = ($urandom_range(0, 4) == 0);
      cmd_ready = ($urandom_range(0, 3) != 0);
      tick      = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 7) == 0) down = ~down;
      if ($urandom_range(0, 49) == 0) score = 14'($urandom_range(0, 120));
      gameover  = ($urandom_range(0, 60) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
